// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency-sweep sequencer.
// Contents:
//   DwellWidthDefault - default width of the dwell counter
//   sweep_state_e     - sequencer FSM states
//   sweep_dir_t       - sweep direction (up or down)
package dds_pkg;

  localparam int unsigned DwellWidthDefault = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDwell,
    StWaitZero,
    StDone
  } sweep_state_e;

  typedef enum logic {
    DirUp,
    DirDown
  } sweep_dir_t;

endpackage

// File: rtl/dds_step_next.sv
// Combinational next-step calculator for the sweep sequencer.
// Ports:
//   cur        - current step value
//   stop_step  - final step value of the sweep
//   delta_step - unsigned step magnitude
//   dir        - sweep direction
//   next_step  - next step value, clamped to stop_step
module dds_step_next
  import dds_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic [ADDRESS_WIDTH-1:0] cur,
  input  logic [ADDRESS_WIDTH-1:0] stop_step,
  input  logic [ADDRESS_WIDTH-1:0] delta_step,
  input  sweep_dir_t               dir,
  output logic [ADDRESS_WIDTH-1:0] next_step
);

  // One extra bit so neither direction can wrap around the step range.
  logic [ADDRESS_WIDTH:0] sum;
  logic [ADDRESS_WIDTH:0] diff;

  assign sum  = {1'b0, cur} + {1'b0, delta_step};
  assign diff = {1'b0, cur} - {1'b0, stop_step};

  always_comb begin
    next_step = stop_step;
    if (dir == DirUp) begin
      if (sum < {1'b0, stop_step}) begin
        next_step = sum[ADDRESS_WIDTH-1:0];
      end
    end else begin
      if (diff > {1'b0, delta_step}) begin
        next_step = cur - delta_step;
      end
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the SET/step_in pair of a DDS.
// Steps the phase increment from start_step to stop_step by delta_step, holding each
// step for a programmable dwell, optionally aligned to the DDS phase-zero flag.
// Ports:
//   CLK, RESET     - clock and asynchronous active-high reset
//   start, abort   - begin a sweep (IDLE only) / terminate any sweep (abort wins)
//   repeat_mode    - 1 = restart from start_step after each pass
//   sync_zero      - 1 = gate step changes on zero_address
//   start_step, stop_step, delta_step, dwell - sweep configuration, latched on start
//   zero_address   - DDS phase-counter-zero flag
//   SET, step_out  - load pulse and step value for the DDS
//   busy, done     - sweep active / end-of-pass pulse
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned INITIAL_STEP  = 1,
  parameter int unsigned DWELL_WIDTH   = DwellWidthDefault
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     repeat_mode,
  input  logic                     sync_zero,
  input  logic [ADDRESS_WIDTH-1:0] start_step,
  input  logic [ADDRESS_WIDTH-1:0] stop_step,
  input  logic [ADDRESS_WIDTH-1:0] delta_step,
  input  logic [DWELL_WIDTH-1:0]   dwell,
  input  logic                     zero_address,
  output logic                     SET,
  output logic [ADDRESS_WIDTH-1:0] step_out,
  output logic                     busy,
  output logic                     done
);

  sweep_state_e             state_q;
  sweep_dir_t               dir_q;
  logic [ADDRESS_WIDTH-1:0] cur_q;
  logic [ADDRESS_WIDTH-1:0] start_q;
  logic [ADDRESS_WIDTH-1:0] stop_q;
  logic [ADDRESS_WIDTH-1:0] delta_q;
  logic [DWELL_WIDTH-1:0]   dwell_q;
  logic [DWELL_WIDTH-1:0]   cnt_q;
  logic                     repeat_q;
  logic                     sync_q;

  logic [ADDRESS_WIDTH-1:0] next_step;
  logic                     dwell_expired;
  logic                     last_step;

  // cnt_q is loaded with the dwell on every SET, so reaching 1 means the dwell ends this cycle.
  assign dwell_expired = (cnt_q == DWELL_WIDTH'(1));
  // A zero delta can never reach stop, so it is a single-step sweep.
  assign last_step     = (cur_q == stop_q) || (delta_q == '0);

  dds_step_next #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_step_next (
    .cur       (cur_q),
    .stop_step (stop_q),
    .delta_step(delta_q),
    .dir       (dir_q),
    .next_step (next_step)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      dir_q    <= DirUp;
      cur_q    <= ADDRESS_WIDTH'(INITIAL_STEP);
      start_q  <= '0;
      stop_q   <= '0;
      delta_q  <= '0;
      dwell_q  <= DWELL_WIDTH'(1);
      cnt_q    <= DWELL_WIDTH'(1);
      repeat_q <= 1'b0;
      sync_q   <= 1'b0;
      SET      <= 1'b0;
      step_out <= ADDRESS_WIDTH'(INITIAL_STEP);
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      SET  <= 1'b0;
      done <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q <= StIdle;
        busy    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !abort) begin
              start_q  <= start_step;
              stop_q   <= stop_step;
              delta_q  <= delta_step;
              // A dwell of 0 behaves as 1.
              dwell_q  <= (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
              dir_q    <= (stop_step >= start_step) ? DirUp : DirDown;
              repeat_q <= repeat_mode;
              sync_q   <= sync_zero;
              busy     <= 1'b1;
              state_q  <= StLoad;
            end
          end
          StLoad: begin
            cur_q    <= start_q;
            step_out <= start_q;
            SET      <= 1'b1;
            cnt_q    <= dwell_q;
            state_q  <= StDwell;
          end
          StDwell: begin
            if (dwell_expired) begin
              if (last_step) begin
                done    <= 1'b1;
                state_q <= StDone;
              end else if (sync_q) begin
                state_q <= StWaitZero;
              end else begin
                cur_q    <= next_step;
                step_out <= next_step;
                SET      <= 1'b1;
                cnt_q    <= dwell_q;
              end
            end else begin
              cnt_q <= cnt_q - DWELL_WIDTH'(1);
            end
          end
          StWaitZero: begin
            if (zero_address) begin
              cur_q    <= next_step;
              step_out <= next_step;
              SET      <= 1'b1;
              cnt_q    <= dwell_q;
              state_q  <= StDwell;
            end
          end
          StDone: begin
            if (repeat_q) begin
              state_q <= StLoad;
            end else begin
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end
          default: begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table of directed sweeps, random sweeps against a
// step/timing model, and hand sequences for repeat/abort and asynchronous reset.
module tb_dds_sweep_ctrl;

  localparam int ZN = 65536;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        repeat_mode = 1'b0;
  logic        sync_zero = 1'b0;
  logic        zero_address = 1'b0;
  logic [7:0]  start_step = '0;
  logic [7:0]  stop_step = '0;
  logic [7:0]  delta_step = '0;
  logic [15:0] dwell = '0;
  logic        SET;
  logic        busy;
  logic        done;
  logic [7:0]  step_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit zpat [ZN];

  typedef struct {
    logic [7:0]  st;
    logic [7:0]  sp;
    logic [7:0]  dl;
    logic [15:0] dw;
    logic        sy;
    bit          poke;
    int          zlow;
    int          exp_n;
    logic [7:0]  exp_last;
    int          exp_gap;
  } vec_t;

  dds_sweep_ctrl #(
    .ADDRESS_WIDTH(8),
    .INITIAL_STEP (1),
    .DWELL_WIDTH  (16)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .start       (start),
    .abort       (abort),
    .repeat_mode (repeat_mode),
    .sync_zero   (sync_zero),
    .start_step  (start_step),
    .stop_step   (stop_step),
    .delta_step  (delta_step),
    .dwell       (dwell),
    .zero_address(zero_address),
    .SET         (SET),
    .step_out    (step_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) begin
    #1;
    zero_address = zpat[cyc % ZN];
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Runs one single-pass sweep and compares every SET, done and busy edge with a model
  // built from the sweep rules (list of step values, then their timing).
  task automatic run_sweep(input logic [7:0] st, input logic [7:0] sp, input logic [7:0] dl,
                           input logic [15:0] dw, input logic sy, input bit poke,
                           input int zlow, output int n_set, output logic [7:0] last_val,
                           output int gap01);
    int s, p, dd, d, v, t0, t, c, done_c, end_c;
    int exp_cyc[$];
    int exp_val[$];
    int act_cyc[$];
    int act_val[$];
    int done_cyc[$];
    bit stray;
    logic [7:0] prev;
    s = int'(st);
    p = int'(sp);
    dd = int'(dl);
    d = (dw == 0) ? 1 : int'(dw);
    v = s;
    exp_val.push_back(v);
    if (dd != 0) begin
      while (v != p) begin
        if (p >= s) v = (v + dd >= p) ? p : v + dd;
        else        v = (v - p <= dd) ? p : v - dd;
        exp_val.push_back(v);
      end
    end
    @(posedge CLK);
    #1;
    t0 = cyc;
    start = 1'b1;
    start_step = st;
    stop_step = sp;
    delta_step = dl;
    dwell = dw;
    sync_zero = sy;
    repeat_mode = 1'b0;
    if (zlow >= 0) begin
      for (int i = 0; i < zlow; i++) zpat[(t0 + 2 + d + i) % ZN] = 1'b0;
      zpat[(t0 + 2 + d + zlow) % ZN] = 1'b1;
    end
    t = t0 + 2;
    exp_cyc.push_back(t);
    for (int i = 1; i < exp_val.size(); i++) begin
      if (sy) begin
        c = t + d;
        while (!zpat[c % ZN] && c < t + d + 2000) c++;
        t = c + 1;
      end else begin
        t = t + d;
      end
      exp_cyc.push_back(t);
    end
    done_c = t + d;
    end_c = done_c + 3;
    prev = step_out;
    stray = 1'b0;
    while (cyc < end_c) begin
      @(negedge CLK);
      if (cyc > t0) begin
        start = poke && (cyc == t0 + 3);
        start_step = 8'($urandom);
        stop_step = 8'($urandom);
        delta_step = 8'($urandom);
        dwell = 16'($urandom_range(0, 3));
        sync_zero = 1'($urandom);
      end
      if (SET === 1'b1) begin
        act_cyc.push_back(cyc);
        act_val.push_back(int'(step_out));
      end else if (step_out !== prev) begin
        stray = 1'b1;
      end
      prev = step_out;
      if (done === 1'b1) done_cyc.push_back(cyc);
      if (cyc == t0 + 1) chk("busy_rise", busy, 1);
      if (cyc == done_c) chk("busy_at_done", busy, 1);
      if (cyc == done_c + 1) chk("busy_fall", busy, 0);
    end
    start = 1'b0;
    chk("set_count", act_cyc.size(), exp_cyc.size());
    for (int i = 0; i < act_cyc.size() && i < exp_cyc.size(); i++) begin
      chk("set_cycle", act_cyc[i] - t0, exp_cyc[i] - t0);
      chk("set_value", act_val[i], exp_val[i]);
    end
    chk("done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("done_cycle", done_cyc[0] - t0, done_c - t0);
    chk("step_hold", stray, 0);
    n_set = act_cyc.size();
    last_val = (act_val.size() > 0) ? 8'(act_val[act_val.size() - 1]) : 8'hxx;
    gap01 = (act_cyc.size() >= 2) ? act_cyc[1] - act_cyc[0] : -1;
  endtask

  initial begin
    vec_t tbl [7];
    int n, gap, t0, off;
    logic [7:0] last;
    bit busy_ok, quiet;

    for (int i = 0; i < ZN; i++) zpat[i] = ($urandom_range(0, 2) == 0);

    tbl[0] = '{8'd4,   8'd10,  8'd3,   16'd5, 1'b0, 1'b0, -1, 3, 8'd10,  5};
    tbl[1] = '{8'd200, 8'd190, 8'd4,   16'd2, 1'b0, 1'b0, -1, 4, 8'd190, 2};
    tbl[2] = '{8'd9,   8'd20,  8'd0,   16'd0, 1'b0, 1'b1, -1, 1, 8'd9,  -1};
    tbl[3] = '{8'd5,   8'd5,   8'd7,   16'd3, 1'b0, 1'b0, -1, 1, 8'd5,  -1};
    tbl[4] = '{8'd0,   8'd255, 8'd100, 16'd1, 1'b0, 1'b0, -1, 4, 8'd255, 1};
    tbl[5] = '{8'd255, 8'd0,   8'd200, 16'd2, 1'b1, 1'b0, -1, 3, 8'd0,  -1};
    tbl[6] = '{8'd10,  8'd12,  8'd5,   16'd3, 1'b1, 1'b0,  7, 2, 8'd12, 11};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_set", SET, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_step", step_out, 1);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_sweep(tbl[i].st, tbl[i].sp, tbl[i].dl, tbl[i].dw, tbl[i].sy, tbl[i].poke,
                tbl[i].zlow, n, last, gap);
      chk("tbl_n", n, tbl[i].exp_n);
      chk("tbl_last", last, tbl[i].exp_last);
      if (tbl[i].exp_gap >= 0) chk("tbl_gap", gap, tbl[i].exp_gap);
    end

    // Random sweeps
    for (int i = 0; i < 15; i++) begin
      logic [7:0] rst_v, rsp_v, rdl_v;
      rst_v = 8'($urandom);
      rsp_v = 8'($urandom);
      rdl_v = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(3, 80));
      run_sweep(rst_v, rsp_v, rdl_v, 16'($urandom_range(0, 4)), 1'($urandom), 1'b0, -1,
                n, last, gap);
    end

    // start together with abort in IDLE: abort wins
    @(negedge CLK);
    start = 1'b1;
    abort = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    abort = 1'b0;
    @(negedge CLK);
    chk("abort_prio_busy", busy, 0);

    // Repeat mode: 1,2,3,done,(load) with period 5, then abort
    @(posedge CLK);
    #1;
    t0 = cyc;
    start = 1'b1;
    start_step = 8'd1;
    stop_step = 8'd3;
    delta_step = 8'd1;
    dwell = 16'd1;
    repeat_mode = 1'b1;
    sync_zero = 1'b0;
    busy_ok = 1'b1;
    while (cyc < t0 + 17) begin
      @(negedge CLK);
      if (cyc > t0) start = 1'b0;
      if (cyc >= t0 + 1 && busy !== 1'b1) busy_ok = 1'b0;
      if (cyc >= t0 + 2) begin
        off = (cyc - t0 - 2) % 5;
        chk("rep_set", SET, off < 3);
        if (off < 3) chk("rep_val", step_out, 1 + off);
        chk("rep_done", done, off == 3);
      end
    end
    chk("rep_busy", busy_ok, 1);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    repeat_mode = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_set", SET, 0);
    chk("abort_done", done, 0);
    chk("abort_step", step_out, 1);
    quiet = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (SET !== 1'b0 || done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("abort_quiet", quiet, 1);

    // Asynchronous reset mid-dwell
    @(posedge CLK);
    #1;
    start = 1'b1;
    start_step = 8'd77;
    stop_step = 8'd200;
    delta_step = 8'd10;
    dwell = 16'd20;
    sync_zero = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    chk("pre_rst_step", step_out, 77);
    chk("pre_rst_busy", busy, 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("rst_set", SET, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step_out, 1);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    chk("post_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
